vga_timing_pwm_gen: RTL and testbench
=====================================

// Module: vga_timing_pwm_gen
// PURPOSE
//  Parametrised VGA raster generator: successor to horizontal_vertical_counter.
//  Generates hsync/vsync, active-video flag and pixel coordinates for any timing set.
//  Gates per-channel colour with a PWM brightness dimmer.
//  Sits between the colour source (switch/pattern logic) and the VGA connector pins.
//  Runs on the board clock, advancing one pixel per pix_en tick.
// PARAMETERS
//  H_ACTIVE 640 visible px/line | H_FP 16 | H_SYNC 96 | H_BP 48  (pixels)
//  V_ACTIVE 480 visible lines   | V_FP 10 | V_SYNC 2  | V_BP 33  (lines)
//  SYNC_POL    0    sync active level (0 = active-low, 640x480 standard)
//  COLOR_W     4    bits per colour channel
//  DUTY_W      27   width of duty_value
//  PWM_PERIOD  100  PWM period in pixel ticks; duty_value is in the same units
// PORTS
//  mhz_clk     in   1        system clock; all logic on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  pix_en      in   1        pixel tick (e.g. 25 MHz strobe); all state advances only when 1
//  red_in      in   COLOR_W  colour for pixel (pix_x,pix_y); green_in, blue_in identical
//  duty_value  in   DUTY_W   brightness, 0..PWM_PERIOD (values >= PERIOD = full on)
//  hsync       out  1        horizontal sync, level per SYNC_POL
//  vsync       out  1        vertical sync, level per SYNC_POL
//  red/green/blue out COLOR_W gated, registered colour to DAC pins
//  video_on    out  1        registered: current output pixel is in active area
//  pix_x       out  clog2(H_TOTAL)  horizontal counter (position being fetched)
//  pix_y       out  clog2(V_TOTAL)  vertical counter
//  frame_start out  1        one mhz_clk pulse when counters wrap to (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Reset (async, rst_n=0): pix_x=pix_y=0, pwm_cnt=0, duty shadow=0.
//    All colours 0, video_on=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
//  - pix_en=0: every register holds; frame_start forced 0.
//  - On pix_en: pix_x++. At H_TOTAL-1, pix_x wraps to 0 and pix_y++.
//    pix_y wraps to 0 after V_TOTAL-1 on the same edge as pix_x wrap.
//  - Output stage, 1 pix_en latency; registered from the pre-increment (pix_x,pix_y):
//      video_on <= x<H_ACTIVE && y<V_ACTIVE
//      hsync    <= SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL
//      vsync    <= same rule on y with the V_* parameters
//      colour   <= (active && pwm_on) ? *_in : 0
//  - PWM: pwm_cnt 0..PWM_PERIOD-1, advances each pix_en, free-running across lines.
//    pwm_on = (pwm_cnt < duty_shadow). duty_shadow=0 gives black;
//    duty_shadow >= PERIOD gives always on.
//  - duty_value is captured into duty_shadow only on the frame wrap edge (no mid-frame tearing).
//    First frame after reset is therefore dark.
//  - frame_start = 1 for exactly the mhz_clk cycle after the pix_en edge that wraps to (0,0).
//  - Reset mid-line: outputs go inactive immediately (asynchronous); raster restarts at (0,0).
//  - Width rule: comparisons are unsigned. duty_value is compared zero-extended to DUTY_W.
// STRUCTURE
//  - Package vga_timing_pkg: 640x480@60 constants, H_TOTAL/V_TOTAL functions,
//    SYNC_ACTIVE_LOW/HIGH localparams.
//  - Sub-module vga_pwm_dimmer: pwm_cnt, duty shadow, pwm_on.
//    Ports: mhz_clk, rst_n, pix_en, load, duty_value, pwm_on.
//  - Top holds the h/v counters and the registered output stage.
// TESTING
//  1. rst_n low 3 cycles mid-frame -> hsync=vsync=1, colours 0, pix_x=pix_y=0 while low.
//  2. pix_en every 4th clk, duty=100, rgb_in=F/F/F -> hsync low exactly 96 ticks per 800-tick line.
//     vsync low 2 lines of 525; video_on for 640x480 ticks.
//  3. duty=50 -> within active area rgb=F for 50 of every 100 pix_en ticks, else 0.
//     duty=0 -> always 0; duty=200 -> always F.
//  4. Change duty 100->0 mid-frame -> output unchanged until frame_start, then black.
//  5. Params H_ACTIVE=8,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1, SYNC_POL=1
//     -> line 12 ticks, frame 84 ticks, sync pulses high; frame_start every 84 pix_en.
//  6. Hold pix_en=0 for 50 clks -> all outputs and counters stable; frame_start stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator family.
package vga_timing_pkg;

    // 640x480 @ 60 Hz horizontal timing, in pixels
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;

    // 640x480 @ 60 Hz vertical timing, in lines
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // Level driven on hsync/vsync while the pulse is asserted
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Registered per-pixel flags produced by the output stage
    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } raster_flags_t;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing_pwm_gen_if.sv
// Pixel-side bundle between the colour source (master) and the raster generator (slave).
interface vga_timing_pwm_gen_if #(
    parameter int COLOR_W = 4,
    parameter int DUTY_W  = 27,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic               pix_en;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;
    logic [DUTY_W-1:0]  duty_value;

    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               video_on;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               frame_start;

    modport master (
        output pix_en, red_in, green_in, blue_in, duty_value,
        input  hsync, vsync, red, green, blue, video_on, pix_x, pix_y, frame_start
    );

    modport slave (
        input  pix_en, red_in, green_in, blue_in, duty_value,
        output hsync, vsync, red, green, blue, video_on, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/vga_pwm_dimmer.sv
// PWM brightness dimmer: free-running period counter plus a frame-synchronous duty shadow.
module vga_pwm_dimmer
    import vga_timing_pkg::*;
#(
    parameter int DUTY_W     = 27,
    parameter int PWM_PERIOD = 100
) (
    input  logic              mhz_clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty_value,
    output logic              pwm_on
);
    localparam int CNT_W = cnt_width(PWM_PERIOD);
    localparam int CMP_W = max_int(DUTY_W, CNT_W);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CMP_W-1:0]  cnt_ext, duty_ext;

    // Next-state: counter wraps at PERIOD-1, shadow only reloads on the frame wrap
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        cnt_d  = cnt_q;
        duty_d = duty_q;
        if (pix_en) begin
            cnt_d = (cnt_q == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        if (load) begin
            duty_d = duty_value;
        end
    end

    // State registers; a zero shadow after reset keeps the first frame dark
    always_ff @(posedge mhz_clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    // Unsigned compare in a common width; duty >= PERIOD therefore means always on
    always_comb begin
        cnt_ext  = CMP_W'(cnt_q);
        duty_ext = CMP_W'(duty_q);
        pwm_on   = (cnt_ext < duty_ext);
    end

endmodule

// File: rtl/vga_timing_pwm_gen.sv
// Parametrised VGA raster generator with PWM-dimmed, registered colour outputs.
module vga_timing_pwm_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int COLOR_W    = 4,
    parameter int DUTY_W     = 27,
    parameter int PWM_PERIOD = 100
) (
    input  logic                 mhz_clk,
    input  logic                 rst_n,
    vga_timing_pwm_gen_if.slave  vga
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int X_W     = cnt_width(H_TOTAL);
    localparam int Y_W     = cnt_width(V_TOTAL);

    // Sync windows as 32-bit bounds so a zero back porch cannot overflow the counter width
    localparam logic [31:0] H_SYNC_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYNC_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_SYNC_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYNC_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0]     h_q, h_d;
    logic [Y_W-1:0]     v_q, v_d;
    logic               h_last, v_last, frame_wrap, frame_load;
    logic [31:0]        h_ext, v_ext;
    logic               pwm_on;

    raster_flags_t      flags_q, flags_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               frame_start_q;

    // Wrap detection on the pre-increment position
    always_comb begin
        h_last     = (h_q == X_W'(H_TOTAL - 1));
        v_last     = (v_q == Y_W'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;
        frame_load = vga.pix_en && frame_wrap;
        h_ext      = 32'(h_q);
        v_ext      = 32'(v_q);
    end

    // Raster counter next-state: x every tick, y on the x wrap, both wrap together
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga.pix_en) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + Y_W'(1);
            end else begin
                h_d = h_q + X_W'(1);
            end
        end
    end

    // Raster counters
    always_ff @(posedge mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    vga_pwm_dimmer #(
        .DUTY_W     (DUTY_W),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_dimmer (
        .mhz_clk    (mhz_clk),
        .rst_n      (rst_n),
        .pix_en     (vga.pix_en),
        .load       (frame_load),
        .duty_value (vga.duty_value),
        .pwm_on     (pwm_on)
    );

    // Output-stage decode of the pixel currently being fetched
    always_comb begin
        flags_d.video_on = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
        flags_d.hsync    = (h_ext >= H_SYNC_START && h_ext < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        flags_d.vsync    = (v_ext >= V_SYNC_START && v_ext < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (flags_d.video_on && pwm_on) begin
            red_d   = vga.red_in;
            green_d = vga.green_in;
            blue_d  = vga.blue_in;
        end
    end

    // Registered outputs, one pix_en of latency; frame_start lasts a single clock
    always_ff @(posedge mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= '{video_on: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_load;
            if (vga.pix_en) begin
                flags_q <= flags_d;
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    assign vga.hsync       = flags_q.hsync;
    assign vga.vsync       = flags_q.vsync;
    assign vga.video_on    = flags_q.video_on;
    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;
    assign vga.pix_x       = h_q;
    assign vga.pix_y       = v_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_pwm_gen.sv
// Directed bench: a 640x480 instance for line timing and reset, a tiny instance for frame/PWM behaviour.
module tb_vga_timing_pwm_gen;
    import vga_timing_pkg::*;

    // Tiny raster: line 12 ticks, frame 7 lines = 84 ticks, sync active-high
    localparam int S_HT  = h_total(8, 1, 2, 1);
    localparam int S_VT  = v_total(4, 1, 1, 1);
    localparam int S_XW  = cnt_width(S_HT);
    localparam int S_YW  = cnt_width(S_VT);
    localparam int S_FRM = S_HT * S_VT;
    localparam int D_XW  = cnt_width(800);
    localparam int D_YW  = cnt_width(525);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_pwm_gen_if #(.COLOR_W(4), .DUTY_W(27), .X_W(D_XW), .Y_W(D_YW)) if_std ();
    vga_timing_pwm_gen_if #(.COLOR_W(4), .DUTY_W(27), .X_W(S_XW), .Y_W(S_YW)) if_sm ();

    vga_timing_pwm_gen u_std (
        .mhz_clk (clk),
        .rst_n   (rst_n),
        .vga     (if_std)
    );

    vga_timing_pwm_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (SYNC_ACTIVE_HIGH), .COLOR_W (4), .DUTY_W (27), .PWM_PERIOD (100)
    ) u_sm (
        .mhz_clk (clk),
        .rst_n   (rst_n),
        .vga     (if_sm)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the tiny raster
    int mx, my, mpwm, mduty;
    logic       l_vid, l_hs, l_vs;
    logic [3:0] l_r, l_g, l_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One pix_en tick every 4th clock on the 640x480 instance, returns on the sample negedge
    task automatic std_tick();
        repeat (2) @(negedge clk);
        @(negedge clk) if_std.pix_en = 1'b1;
        @(negedge clk) if_std.pix_en = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_std_hsync", 32'(if_std.hsync), 1);
        check("rst_std_vsync", 32'(if_std.vsync), 1);
        check("rst_std_rgb",   {20'd0, if_std.red, if_std.green, if_std.blue}, 0);
        check("rst_std_video", 32'(if_std.video_on), 0);
        check("rst_std_fs",    32'(if_std.frame_start), 0);
        check("rst_std_x",     32'(if_std.pix_x), 0);
        check("rst_std_y",     32'(if_std.pix_y), 0);
        check("rst_sm_hsync",  32'(if_sm.hsync), 0);
        check("rst_sm_vsync",  32'(if_sm.vsync), 0);
        check("rst_sm_x",      32'(if_sm.pix_x), 0);
    endtask

    function automatic int duty_for(int t);
        if (t < 124) return 100;
        if (t < 168) return 0;
        if (t < 336) return 50;
        if (t < 420) return 200;
        if (t < 504) return 7;
        return 99;
    endfunction

    task automatic check_sm_outputs(input string pfx, input logic fs_exp);
        check({pfx, "_video"}, 32'(if_sm.video_on), 32'(l_vid));
        check({pfx, "_hsync"}, 32'(if_sm.hsync), 32'(l_hs));
        check({pfx, "_vsync"}, 32'(if_sm.vsync), 32'(l_vs));
        check({pfx, "_red"},   32'(if_sm.red), 32'(l_r));
        check({pfx, "_green"}, 32'(if_sm.green), 32'(l_g));
        check({pfx, "_blue"},  32'(if_sm.blue), 32'(l_b));
        check({pfx, "_fs"},    32'(if_sm.frame_start), 32'(fs_exp));
        check({pfx, "_x"},     32'(if_sm.pix_x), 32'(mx));
        check({pfx, "_y"},     32'(if_sm.pix_y), 32'(my));
    endtask

    // One tiny-raster tick followed by `gap` idle clocks; expectations come from the reference state
    task automatic sm_tick(input int gap, output logic fs_exp);
        logic on;
        l_vid  = (mx < 8) && (my < 4);
        l_hs   = (mx >= 9) && (mx < 11);
        l_vs   = (my >= 5) && (my < 6);
        on     = (mpwm < mduty);
        l_r    = (l_vid && on) ? if_sm.red_in   : 4'h0;
        l_g    = (l_vid && on) ? if_sm.green_in : 4'h0;
        l_b    = (l_vid && on) ? if_sm.blue_in  : 4'h0;
        fs_exp = (mx == S_HT - 1) && (my == S_VT - 1);
        @(negedge clk) if_sm.pix_en = 1'b1;
        @(negedge clk) if_sm.pix_en = 1'b0;
        if (fs_exp) mduty = int'(if_sm.duty_value);
        mpwm = (mpwm == 99) ? 0 : mpwm + 1;
        if (mx == S_HT - 1) begin
            mx = 0;
            my = (my == S_VT - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        check_sm_outputs("sm", fs_exp);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (i == 0) check("sm_fs_one_clk", 32'(if_sm.frame_start), 0);
        end
    endtask

    // Hold pix_en low and change the colour inputs; nothing observable may move
    task automatic sm_hold(input int clks);
        if_sm.red_in   = 4'h0;
        if_sm.green_in = 4'h0;
        if_sm.blue_in  = 4'h0;
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            check_sm_outputs("hold", 1'b0);
        end
    endtask

    initial begin
        int hs_low, hs_first, vid, vid_last, vs_bad, col_nz, fs_cnt;
        int on_cnt [8];
        int last_fs, fs_seen;
        logic fs_e;

        rst_n = 1'b0;
        if_std.pix_en = 1'b1;
        if_std.red_in = 4'hF; if_std.green_in = 4'hF; if_std.blue_in = 4'hF;
        if_std.duty_value = 27'd100;
        if_sm.pix_en = 1'b0;
        if_sm.red_in = 4'hF; if_sm.green_in = 4'hF; if_sm.blue_in = 4'hF;
        if_sm.duty_value = 27'd100;
        mx = 0; my = 0; mpwm = 0; mduty = 0;

        // Reset state, with pix_en high on the 640x480 instance to show it is ignored
        repeat (3) begin
            @(negedge clk);
            check_reset_state();
        end
        @(negedge clk);
        if_std.pix_en = 1'b0;
        rst_n = 1'b1;

        // First 640x480 line: sync width and position, active span, dark first frame
        hs_low = 0; hs_first = -1; vid = 0; vid_last = -1; vs_bad = 0; col_nz = 0; fs_cnt = 0;
        for (int t = 0; t < 800; t++) begin
            std_tick();
            if (t == 0) check("std_x_after_first", 32'(if_std.pix_x), 1);
            if (if_std.hsync === 1'b0) begin
                if (hs_first < 0) hs_first = t;
                hs_low++;
            end
            if (if_std.video_on === 1'b1) begin
                vid++;
                vid_last = t;
            end
            if (if_std.vsync !== 1'b1) vs_bad++;
            if ({if_std.red, if_std.green, if_std.blue} !== 12'h000) col_nz++;
            if (if_std.frame_start !== 1'b0) fs_cnt++;
        end
        check("std_hs_low_ticks", 32'(hs_low), 96);
        check("std_hs_first", 32'(hs_first), 656);
        check("std_video_ticks", 32'(vid), 640);
        check("std_video_last", 32'(vid_last), 639);
        check("std_vsync_line0", 32'(vs_bad), 0);
        check("std_first_frame_dark", 32'(col_nz), 0);
        check("std_fs_none", 32'(fs_cnt), 0);
        check("std_x_wrap", 32'(if_std.pix_x), 0);
        check("std_y_inc", 32'(if_std.pix_y), 1);

        // Reset in the middle of the hsync pulse of line 1
        for (int t = 0; t < 700; t++) std_tick();
        check("std_hs_pre_rst", 32'(if_std.hsync), 0);
        check("std_x_pre_rst", 32'(if_std.pix_x), 700);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("async_hsync", 32'(if_std.hsync), 1);
        check("async_x", 32'(if_std.pix_x), 0);
        check("async_y", 32'(if_std.pix_y), 0);
        repeat (3) begin
            @(negedge clk);
            check_reset_state();
        end
        rst_n = 1'b1;
        std_tick();
        check("restart_x", 32'(if_std.pix_x), 1);
        check("restart_y", 32'(if_std.pix_y), 0);
        check("restart_hsync", 32'(if_std.hsync), 1);
        check("restart_video", 32'(if_std.video_on), 1);

        // Tiny raster: eight frames with a duty schedule and two pix_en holds
        foreach (on_cnt[i]) on_cnt[i] = 0;
        last_fs = -1;
        fs_seen = 0;
        for (int t = 0; t < 8 * S_FRM; t++) begin
            if_sm.red_in     = 4'hF;
            if_sm.green_in   = 4'(t) | 4'h1;
            if_sm.blue_in    = 4'(t * 7);
            if_sm.duty_value = 27'(duty_for(t));
            sm_tick(t % 3, fs_e);
            if (if_sm.red !== 4'h0) on_cnt[t / S_FRM]++;
            if (fs_e) begin
                if (last_fs >= 0) check("sm_fs_period", 32'(t - last_fs), 32'(S_FRM));
                last_fs = t;
                fs_seen++;
            end
            if (t == S_FRM - 1 || t == S_FRM + 13) sm_hold(50);
        end
        check("sm_fs_count", 32'(fs_seen), 8);
        check("sm_frame0_dark", 32'(on_cnt[0]), 0);
        check("sm_duty100_full", 32'(on_cnt[1]), 32);
        check("sm_duty0_black", 32'(on_cnt[2]), 0);
        check("sm_duty200_full", 32'(on_cnt[5]), 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
